// File: rtl/load_store_sequencer_if.sv
// Bundle of CPU-request, DMEM and response signals around the load/store sequencer.
// The master side drives requests and memory read data; the slave side is the sequencer.
interface load_store_sequencer_if #(
   parameter int ADDR_WIDTH = 14
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_is_store;
   logic [2:0]            req_funct3;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic                  mem_en;
   logic [3:0]            mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  resp_valid;
   logic [31:0]           resp_data;
   logic                  resp_misaligned;

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  resp_valid, resp_data, resp_misaligned
   );

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output resp_valid, resp_data, resp_misaligned
   );
endinterface

// File: rtl/load_store_sequencer.sv
// Splits CPU loads/stores into one or two DMEM word accesses, merging and extending load data
// and shifting store data/byte enables across the word boundary.
module load_store_sequencer #(
   parameter int ADDR_WIDTH       = 14,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   load_store_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [31:0] load_extract(input logic [63:0] pair, input logic [1:0] off,
                                                input logic is_half, input logic is_word,
                                                input logic zext);
      logic [31:0] low;
      low = 32'(pair >> {off, 3'b000});
      if (is_word) begin
         return low;
      end else if (is_half) begin
         return zext ? {16'h0000, low[15:0]} : {{16{low[15]}}, low[15:0]};
      end else begin
         return zext ? {24'h000000, low[7:0]} : {{24{low[7]}}, low[7:0]};
      end
   endfunction

   state_t                state_r;
   state_t                state_next_s;
   logic                  accept_s;
   logic [1:0]            off_raw_s;
   logic [1:0]            off_s;
   logic                  is_half_s;
   logic                  is_word_s;
   logic                  mis_s;
   logic                  split_s;
   logic [3:0]            size_mask_s;
   logic [7:0]            mask64_s;
   logic [63:0]           data64_s;
   logic [ADDR_WIDTH-1:0] word0_s;
   logic [ADDR_WIDTH-1:0] word1_s;
   logic [63:0]           pair_s;

   logic                  is_store_r;
   logic                  zext_r;
   logic                  is_half_r;
   logic                  is_word_r;
   logic                  mis_r;
   logic                  split_r;
   logic [1:0]            off_r;
   logic [ADDR_WIDTH-1:0] word1_r;
   logic [31:0]           wdata_hi_r;
   logic [3:0]            we_hi_r;
   logic [31:0]           rdata0_r;

   logic                  req_ready_r;
   logic                  mem_en_r;
   logic [3:0]            mem_we_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]           mem_wdata_r;
   logic                  resp_valid_r;
   logic [31:0]           resp_data_r;
   logic                  resp_mis_r;
   logic                  req_ready_s;
   logic                  mem_en_s;
   logic [3:0]            mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [31:0]           mem_wdata_s;
   logic                  resp_valid_s;
   logic [31:0]           resp_data_s;
   logic                  resp_mis_s;
   logic                  unused_addr_s;

   assign accept_s      = bus.req_valid & req_ready_r;
   assign unused_addr_s = ^bus.req_addr[31:ADDR_WIDTH+2];

   // Request decode: size, offset, split decision and the 64-bit shifted store image.
   always_comb begin
      off_raw_s = bus.req_addr[1:0];
      is_word_s = bus.req_funct3[1];
      is_half_s = (bus.req_funct3[1:0] == 2'b01);
      mis_s     = (is_half_s & off_raw_s[0]) | (is_word_s & (off_raw_s != 2'b00));
      if (ALLOW_MISALIGNED) begin
         off_s   = off_raw_s;
         split_s = (is_half_s & (off_raw_s == 2'b11)) | (is_word_s & (off_raw_s != 2'b00));
      end else begin
         split_s = 1'b0;
         if (is_word_s) begin
            off_s = 2'b00;
         end else if (is_half_s) begin
            off_s = {off_raw_s[1], 1'b0};
         end else begin
            off_s = off_raw_s;
         end
      end
      if (is_word_s) begin
         size_mask_s = 4'b1111;
      end else if (is_half_s) begin
         size_mask_s = 4'b0011;
      end else begin
         size_mask_s = 4'b0001;
      end
      mask64_s = {4'b0000, size_mask_s} << off_s;
      data64_s = {32'h0000_0000, bus.req_wdata} << {off_s, 3'b000};
      word0_s  = bus.req_addr[ADDR_WIDTH+1:2];
      word1_s  = word0_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   end

   // Unsplit loads see only the first word, so the upper half of the pair is zero.
   always_comb begin
      if (split_r) begin
         pair_s = {bus.mem_rdata, rdata0_r};
      end else begin
         pair_s = {32'h0000_0000, bus.mem_rdata};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; stores bypass WAIT because nothing comes back from DMEM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = ACC0;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACC0: begin
            if (split_r) begin
               state_next_s = ACC1;
            end else if (is_store_r) begin
               state_next_s = DONE;
            end else begin
               state_next_s = WAIT;
            end
         end
         ACC1: begin
            if (is_store_r) begin
               state_next_s = DONE;
            end else begin
               state_next_s = WAIT;
            end
         end
         WAIT:    state_next_s = DONE;
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the state being left.
   always_comb begin
      req_ready_s  = (state_next_s == IDLE);
      mem_en_s     = 1'b0;
      mem_we_s     = 4'b0000;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      resp_valid_s = 1'b0;
      resp_data_s  = resp_data_r;
      resp_mis_s   = resp_mis_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               mem_en_s    = 1'b1;
               mem_we_s    = bus.req_is_store ? mask64_s[3:0] : 4'b0000;
               mem_addr_s  = word0_s;
               mem_wdata_s = data64_s[31:0];
            end else begin
               mem_en_s = 1'b0;
            end
         end
         ACC0: begin
            if (split_r) begin
               mem_en_s    = 1'b1;
               mem_we_s    = is_store_r ? we_hi_r : 4'b0000;
               mem_addr_s  = word1_r;
               mem_wdata_s = wdata_hi_r;
            end else if (is_store_r) begin
               resp_valid_s = 1'b1;
               resp_data_s  = 32'h0000_0000;
               resp_mis_s   = mis_r;
            end else begin
               resp_valid_s = 1'b0;
            end
         end
         ACC1: begin
            if (is_store_r) begin
               resp_valid_s = 1'b1;
               resp_data_s  = 32'h0000_0000;
               resp_mis_s   = mis_r;
            end else begin
               resp_valid_s = 1'b0;
            end
         end
         WAIT: begin
            resp_valid_s = 1'b1;
            resp_data_s  = load_extract(pair_s, off_r, is_half_r, is_word_r, zext_r);
            resp_mis_s   = mis_r;
         end
         DONE:    resp_valid_s = 1'b0;
         default: resp_valid_s = 1'b0;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_r  <= 1'b1;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 4'b0000;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r  <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_data_r  <= 32'h0000_0000;
         resp_mis_r   <= 1'b0;
      end else begin
         req_ready_r  <= req_ready_s;
         mem_en_r     <= mem_en_s;
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
         resp_valid_r <= resp_valid_s;
         resp_data_r  <= resp_data_s;
         resp_mis_r   <= resp_mis_s;
      end
   end

   // Request latch; the first word of a split load is parked here while the second is read.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_store_r <= 1'b0;
         zext_r     <= 1'b0;
         is_half_r  <= 1'b0;
         is_word_r  <= 1'b0;
         mis_r      <= 1'b0;
         split_r    <= 1'b0;
         off_r      <= 2'b00;
         word1_r    <= {ADDR_WIDTH{1'b0}};
         wdata_hi_r <= 32'h0000_0000;
         we_hi_r    <= 4'b0000;
         rdata0_r   <= 32'h0000_0000;
      end else if (accept_s) begin
         is_store_r <= bus.req_is_store;
         zext_r     <= bus.req_funct3[2];
         is_half_r  <= is_half_s;
         is_word_r  <= is_word_s;
         mis_r      <= mis_s;
         split_r    <= split_s;
         off_r      <= off_s;
         word1_r    <= word1_s;
         wdata_hi_r <= data64_s[63:32];
         we_hi_r    <= mask64_s[7:4];
      end else if (state_r == ACC1) begin
         rdata0_r <= bus.mem_rdata;
      end
   end

   assign bus.req_ready       = req_ready_r;
   assign bus.mem_en          = mem_en_r;
   assign bus.mem_we          = mem_we_r;
   assign bus.mem_addr        = mem_addr_r;
   assign bus.mem_wdata       = mem_wdata_r;
   assign bus.resp_valid      = resp_valid_r;
   assign bus.resp_data       = resp_data_r;
   assign bus.resp_misaligned = resp_mis_r;
endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Sits between the CPU memory stage and the single-ported data memory (DMEM).
- Accepts one load/store request at a time and issues one or two word accesses to DMEM. A misaligned access that crosses a word boundary is split into two accesses.
- For loads, merges the returned words and performs byte/half extraction with sign/zero extension.
- For stores, generates shifted write data and per-word byte enables.

Parameters:
ADDR_WIDTH, 14, DMEM word-index width; byte address space is 2^(ADDR_WIDTH+2).
ALLOW_MISALIGNED, 1, 1: split boundary-crossing accesses; 0: clear offset bits below natural alignment and flag misaligned.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (IDLE only)
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data (right-aligned)
mem_en  out  1  DMEM access enable
mem_we  out  4  DMEM byte write enables
mem_addr  out  ADDR_WIDTH  DMEM word index
mem_wdata  out  32  DMEM write data
mem_rdata  in  32  DMEM read data, valid the cycle after a read
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result (0 for stores)
resp_misaligned  out  1  access was misaligned (valid with resp_valid)

Behaviour:
- States: IDLE, ACC0, ACC1, WAIT, DONE.
- All mem_* and resp_* outputs are registered.
- Reset values: req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_misaligned=0, state=IDLE.
- Acceptance:
  - A request is accepted on a clock edge where req_valid&req_ready (cycle T).
  - All request fields are latched on that edge; req_ready=0 until the sequencer returns to IDLE.
- Decoding:
  - Offset: off=addr[1:0].
  - Size from funct3[1:0]: 00 byte, 01 half, 10/11 word.
  - Loads: funct3[2] selects zero-extension; 011/110/111 are treated as LW.
- Split rule:
  - Half splits when off==3; word splits when off!=0; bytes never split.
  - Only when ALLOW_MISALIGNED=1.
  - misaligned = (half & off[0]) | (word & off!=0).
- Addressing:
  - word0 = addr[ADDR_WIDTH+1:2].
  - word1 = word0+1, wrapping modulo 2^ADDR_WIDTH.
- Store formatting:
  - 64-bit data = {32'b0,wdata} << 8*off; 8-bit mask = sizemask << off.
  - Low half of each goes to word0 (ACC0); high half goes to word1 (ACC1).
  - mem_wdata bytes whose we=0 are don't care.
- Load merge:
  - {rdata1,rdata0} >> 8*off, then extract byte/half/word and extend.
  - Unsplit loads use rdata1 = 0.
- Cycle timing (T = accept cycle):
  - ACC0, cycle T+1: mem_en=1, first access driven.
  - Split access, cycle T+2: ACC1 drives the second access while the first read's rdata is captured.
  - Unsplit load, cycle T+2: WAIT captures rdata.
  - Split load, cycle T+3: WAIT captures the second word.
  - DONE: resp_valid=1 for exactly one cycle; the next cycle is IDLE with req_ready=1.
  - Latency accept→resp_valid: aligned load 3, split load 4, aligned store 2, split store 3.
- mem_en=0 and mem_we=0 in IDLE, WAIT and DONE.
- Stores skip WAIT.
- ALLOW_MISALIGNED=0: offset bits below natural alignment are cleared before access; resp_misaligned still reports the original misalignment.
- Reset mid-operation:
  - Immediate return to IDLE; outputs go to their reset values on the next edge.
  - A pending second half of a split store is never issued; an already-committed first half stays committed.
  - No resp_valid is produced for the aborted request.
- req_valid while busy is ignored; it is not queued.

Test Plan:
- DMEM[0x400]=0x12345678; LB 0x1001 accepted at T → single read of 0x400 at T+1; resp_valid at T+3, resp_data=0x00000056, misaligned=0.
- DMEM[0x400]=0x89ABCDEF, DMEM[0x401]=0x01234567; LW 0x1002 → reads 0x400 (T+1) and 0x401 (T+2); resp at T+4, data=0x456789AB, misaligned=1.
- Same memory, LH 0x1002 → 0xFFFF89AB (3-cycle latency); LHU 0x1003 → split, 0x00006789 (4-cycle latency).
- SW 0x2001 wdata 0xAABBCCDD → T+1: addr 0x800, we=1110, wdata[31:8]=0xBBCCDD; T+2: addr 0x801, we=0001, wdata[7:0]=0xAA; resp at T+3, resp_data=0.
- LW 0xFFFE (ADDR_WIDTH=14), DMEM[0x3FFF]=0x11112222, DMEM[0x0000]=0x33334444 → second read at 0x0000; resp_data=0x44441111.
- Split SW with rst asserted during T+2 → no write with we!=0 after the reset edge, no resp_valid; req_ready=1 on the cycle after rst deasserts; a new LB then completes normally.
